// File: rtl/branch_cmp_seq.sv
// Multi-cycle RISC-V branch comparator: scans operands MSB-first, one CHUNK-bit slice per cycle.
// Define BRANCH_CMP_EARLY_TERM_EN to stop at the first differing slice; otherwise every scan runs NCH slices.
module branch_cmp_seq #(
   parameter int unsigned N     = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [2:0]   op_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic         taken_o,
   output logic         lt_o,
   output logic         eq_o
);

   localparam int unsigned NCH = N / CHUNK;
   localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(NCH - 1);
   localparam logic [N-1:0]  MSB_MASK = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [2:0]      op_q, op_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            lt_q, lt_d;
   logic            eq_q, eq_d;
   logic            taken_q, taken_d;
`ifndef BRANCH_CMP_EARLY_TERM_EN
   logic            decided_q, decided_d;
   logic            lt_scan_q, lt_scan_d;
`endif

   logic [NCH-1:0][CHUNK-1:0] a_sl, b_sl;
   logic [CHUNK-1:0]          sl_a, sl_b;
   logic                      sl_diff, sl_lt;

   assign a_sl    = a_q;
   assign b_sl    = b_q;
   assign sl_a    = a_sl[idx_q];
   assign sl_b    = b_sl[idx_q];
   assign sl_diff = (sl_a != sl_b);
   assign sl_lt   = (sl_a < sl_b);

   function automatic logic branch_taken(input logic [2:0] op, input logic lt, input logic eq);
      logic t;
      case (op)
         3'b000:          t = eq;
         3'b001:          t = ~eq;
         3'b100, 3'b110:  t = lt;
         3'b101, 3'b111:  t = ~lt;
         default:         t = 1'b0;
      endcase
      return t;
   endfunction

   always_ff @(posedge clk_i or negedge rstn_i) begin : state_reg
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin : data_reg
      if (!rstn_i) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         idx_q     <= IDX_TOP;
         lt_q      <= 1'b0;
         eq_q      <= 1'b0;
         taken_q   <= 1'b0;
`ifndef BRANCH_CMP_EARLY_TERM_EN
         decided_q <= 1'b0;
         lt_scan_q <= 1'b0;
`endif
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         lt_q      <= lt_d;
         eq_q      <= eq_d;
         taken_q   <= taken_d;
`ifndef BRANCH_CMP_EARLY_TERM_EN
         decided_q <= decided_d;
         lt_scan_q <= lt_scan_d;
`endif
      end
   end

   always_comb begin : next_comb
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      idx_d     = idx_q;
      lt_d      = lt_q;
      eq_d      = eq_q;
      taken_d   = taken_q;
`ifndef BRANCH_CMP_EARLY_TERM_EN
      decided_d = decided_q;
      lt_scan_d = lt_scan_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               // Flipping the sign bit maps two's-complement order onto unsigned order.
               if (op_i[2:1] == 2'b10) begin
                  a_d = a_i ^ MSB_MASK;
                  b_d = b_i ^ MSB_MASK;
               end else begin
                  a_d = a_i;
                  b_d = b_i;
               end
               op_d      = op_i;
               idx_d     = IDX_TOP;
`ifndef BRANCH_CMP_EARLY_TERM_EN
               decided_d = 1'b0;
               lt_scan_d = 1'b0;
`endif
               state_d   = SCAN;
            end
         end
         SCAN: begin
`ifdef BRANCH_CMP_EARLY_TERM_EN
            if (sl_diff) begin
               lt_d    = sl_lt;
               eq_d    = 1'b0;
               state_d = DONE;
            end else if (idx_q == '0) begin
               lt_d    = 1'b0;
               eq_d    = 1'b1;
               state_d = DONE;
            end else begin
               idx_d   = idx_q - IW'(1);
            end
`else
            if (!decided_q && sl_diff) begin
               decided_d = 1'b1;
               lt_scan_d = sl_lt;
            end
            // lt/eq outputs only change at the end so they hold their last result while scanning.
            if (idx_q == '0) begin
               lt_d    = decided_d ? lt_scan_d : 1'b0;
               eq_d    = ~decided_d;
               state_d = DONE;
            end else begin
               idx_d   = idx_q - IW'(1);
            end
`endif
            if (state_d == DONE) taken_d = branch_taken(op_q, lt_d, eq_d);
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : out_comb
      in_ready_o  = (state_q == IDLE);
      out_valid_o = (state_q == DONE);
      taken_o     = taken_q;
      lt_o        = lt_q;
      eq_o        = eq_q;
   end

endmodule
